jacobi_sweep_controller: RTL and testbench
==========================================

Name: jacobi_sweep_controller

Overview:
- Sequences the grid_solver pipeline through full Jacobi sweeps of the phi grid.
- Per sweep: issues every grid address once in raster order, credit-limits in-flight points, and checks in-order writeback.
- Drains the pipeline, then swaps the ping-pong phi banks (read prev / write new) and repeats for a programmed iteration count.
- Sits between the top-level sim sequencer and grid_solver/phi BRAM bank muxing.

Parameters:
GRID_BITS, 8, bits per axis; grid is 2^GRID_BITS x 2^GRID_BITS.
ITER_W, 8, width of iteration count.
MAX_INFLIGHT, 32, max issued-but-not-written points (must be >= solver latency for full throughput).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin solve; accepted only when busy=0
num_iters  in  ITER_W  sweeps to run, latched on accepted start
stall  in  1  hold issue (e.g. scatterer charge not ready)
solver_valid  out  1  issue strobe to grid_solver valid
grid_addr  out  2*GRID_BITS  issued address, {y,x}, y in upper half
solver_valid_out  in  1  grid_solver writeback strobe
solver_waddr  in  2*GRID_BITS  grid_solver writeback address {y,x}
rd_bank  out  1  phi bank read this sweep; write bank = ~rd_bank
busy  out  1  high in SWEEP/DRAIN/SWAP
done  out  1  one-cycle pulse on solve completion
iter_cnt  out  ITER_W  completed sweeps
err_order  out  1  sticky: writeback address mismatch
err_underflow  out  1  sticky: writeback with zero in-flight

Behaviour:
- Reset: synchronous, acts on the same edge. All outputs and internal state go to 0, state IDLE. Reset mid-sweep abandons the solve; stale writebacks arriving afterwards set err_underflow.
- States: IDLE, SWEEP, DRAIN, SWAP, DONE. DONE behaves as IDLE; busy=0.
- IDLE/DONE + start:
  - Latch num_iters; clear iter_cnt, err flags, issue/expect addresses, wb count.
  - num_iters=0: go to DONE; done pulses on the next cycle.
  - Otherwise go to SWEEP.
- SWEEP issue condition: !stall && inflight < MAX_INFLIGHT.
  - Outputs are registered: solver_valid=1 and grid_addr=issue addr in the cycle after the condition holds; otherwise solver_valid=0.
  - First issue appears 1 cycle after start is accepted.
- Raster order: x increments; at x=all-ones, x wraps to 0 and y increments.
- After issuing {all-ones, all-ones}: go to DRAIN; issue addr wraps to 0.
- Inflight counter, width clog2(MAX_INFLIGHT)+1:
  - +1 on issue, -1 on solver_valid_out; both in the same cycle: unchanged.
  - Never exceeds MAX_INFLIGHT.
  - Writeback at 0 sets err_underflow; counter stays 0.
- Writeback check: each solver_valid_out compares solver_waddr to the expect addr (same raster sequence). Mismatch sets err_order; the expect addr still advances.
- DRAIN: exit to SWAP when inflight=0 and wb count = 2^(2*GRID_BITS).
- SWAP (1 cycle): toggle rd_bank, increment iter_cnt.
  - iter_cnt+1 = num_iters: go to DONE, done=1 in that transition cycle.
  - Otherwise go to SWEEP; wb count clears.
- start while busy: ignored. stall during DRAIN: no effect.
- rd_bank persists across solves; it is not reset by start.

Optional Feature:
SWEEP_PERF_CNT_EN:
- Defined: adds output stall_cycles (32 bit), the count of SWEEP cycles where stall=1 or the credit limit blocked issue. It clears on accepted start and saturates at all-ones. Adds output last_sweep_cycles (32 bit), the cycle count from SWEEP entry to SWAP for the most recent sweep.
- Undefined: ports absent, no counters.

Decomposition:
- Shared package gets grid_coord_t ({y,x} with GRID_BITS fields) and a raster-increment function used by both issue and expect generators.
- Natural sub-module: sweep_credit_counter (inflight up/down counter with limit and underflow flag).
- FSM and address generators stay in the top.

Test Plan:
1. GRID_BITS=2, num_iters=1, solver model with 24-cycle in-order echo -> addresses 0..15 raster; done 1 cycle after the last writeback drains plus SWAP; rd_bank 0->1; iter_cnt=1.
2. num_iters=3 -> three sweeps; rd_bank toggles 3 times; single done pulse; iter_cnt=3.
3. MAX_INFLIGHT=4, 24-cycle echo -> never more than 4 outstanding; issue resumes the cycle after each writeback.
4. stall high for 10 cycles mid-sweep -> no solver_valid during stall; addresses continue from the held point without skip or duplicate.
5. Model swaps two writeback addresses -> err_order=1 and sticky; sweep still completes. Spurious writeback in IDLE -> err_underflow=1.
6. rst asserted mid-SWEEP -> next cycle all outputs 0, state IDLE; num_iters=0 start -> done after 1 cycle, no issues.

Source files
------------

// File: rtl/jacobi_sweep_controller_pkg.sv
// Shared state encoding, grid coordinate type and raster stepping
// used by the Jacobi sweep controller issue and writeback paths.
package jacobi_sweep_controller_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_SWAP,
    S_DONE
  } sweep_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } grid_coord_t;

  function automatic logic [COORD_W-1:0] axis_max(
    input int unsigned bits
  );
    return COORD_W'((32'd1 << bits) - 32'd1);
  endfunction

  // x runs fastest; the last point wraps back to the origin.
  function automatic grid_coord_t raster_next(
    input grid_coord_t c,
    input int unsigned bits
  );
    grid_coord_t n;
    logic [COORD_W-1:0] lim;
    lim = axis_max(bits);
    n = c;
    if (c.x == lim) begin
      n.x = '0;
      n.y = (c.y == lim) ? '0 : c.y + COORD_W'(1);
    end else begin
      n.x = c.x + COORD_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/jacobi_sweep_controller_if.sv
// Issue / writeback bundle between the sweep controller and the
// grid_solver pipeline. Addresses are {y,x}, y in the upper half.
interface jacobi_sweep_controller_if #(
  parameter int GRID_BITS = 8
);
  localparam int AW = 2 * GRID_BITS;

  logic          solver_valid;
  logic [AW-1:0] grid_addr;
  logic          solver_valid_out;
  logic [AW-1:0] solver_waddr;

  modport master (
    output solver_valid,
    output grid_addr,
    input  solver_valid_out,
    input  solver_waddr
  );

  modport slave (
    input  solver_valid,
    input  grid_addr,
    output solver_valid_out,
    output solver_waddr
  );
endinterface

// File: rtl/jacobi_sweep_controller_credit.sv
// sweep_credit_counter: in-flight point counter with an issue limit
// and a sticky flag for writebacks that arrive with nothing in flight.
module sweep_credit_counter #(
  parameter int MAX_INFLIGHT = 32,
  localparam int CW = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          can_issue,
  output logic          underflow
);

  assign can_issue = count < CW'(MAX_INFLIGHT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (clr) underflow <= 1'b0;
      // A writeback with nothing outstanding is bogus and is dropped.
      if (dec && count == '0) begin
        underflow <= 1'b1;
        count     <= count + CW'(inc);
      end else if (inc && !dec) begin
        count <= count + CW'(1);
      end else if (dec && !inc) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/jacobi_sweep_controller.sv
// Jacobi sweep sequencer: raster issue, credit limit, in-order check,
// drain and ping-pong bank swap. SWEEP_PERF_CNT_EN adds perf counters.
module jacobi_sweep_controller
  import jacobi_sweep_controller_pkg::*;
#(
  parameter int GRID_BITS    = 8,
  parameter int ITER_W       = 8,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iters,
  input  logic              stall,
  jacobi_sweep_controller_if.master sif,
  output logic              rd_bank,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              err_order,
  output logic              err_underflow
`ifdef SWEEP_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       last_sweep_cycles
`endif
);

  localparam int AW  = 2 * GRID_BITS;
  localparam int WBW = AW + 1;
  localparam int CW  = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [WBW-1:0] NPTS = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] XMASK =
    {{GRID_BITS{1'b0}}, {GRID_BITS{1'b1}}};

  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a
  );
    grid_coord_t c, n;
    c.y = COORD_W'(a >> GRID_BITS);
    c.x = COORD_W'(a & XMASK);
    n = raster_next(c, GRID_BITS);
    return AW'((32'(n.y) << GRID_BITS) | 32'(n.x));
  endfunction

  sweep_state_t      state;
  logic [ITER_W-1:0] iters;
  logic [AW-1:0]     issue_addr;
  logic [AW-1:0]     exp_addr;
  logic [AW-1:0]     cur_addr;
  logic [WBW-1:0]    wb_cnt;
  logic [CW-1:0]     inflight;
  logic              can_issue;
  logic              idle_like;
  logic              start_acc;
  logic              start_run;
  logic              issue;
  logic              wb;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign start_acc = idle_like && start;
  assign start_run = start_acc && (num_iters != '0);
  // The first point goes out on the same edge that accepts start.
  assign issue     = !stall && can_issue &&
                     ((state == S_SWEEP) || start_run);
  assign cur_addr  = start_acc ? '0 : issue_addr;
  assign wb        = sif.solver_valid_out;
  assign busy      = state inside {S_SWEEP, S_DRAIN, S_SWAP};

  sweep_credit_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .inc       (issue),
    .dec       (wb),
    .count     (inflight),
    .can_issue (can_issue),
    .underflow (err_underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      iters            <= '0;
      iter_cnt         <= '0;
      rd_bank          <= 1'b0;
      done             <= 1'b0;
      err_order        <= 1'b0;
      issue_addr       <= '0;
      exp_addr         <= '0;
      wb_cnt           <= '0;
      sif.solver_valid <= 1'b0;
      sif.grid_addr    <= '0;
    end else begin
      done             <= 1'b0;
      sif.solver_valid <= issue;
      if (wb) begin
        if (sif.solver_waddr != exp_addr) err_order <= 1'b1;
        exp_addr <= next_addr(exp_addr);
        wb_cnt   <= wb_cnt + WBW'(1);
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            iters      <= num_iters;
            iter_cnt   <= '0;
            err_order  <= 1'b0;
            issue_addr <= '0;
            exp_addr   <= '0;
            wb_cnt     <= '0;
            if (num_iters == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SWEEP;
            end
          end
        end
        S_SWEEP: begin
          if (issue && cur_addr == '1) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (inflight == '0 && wb_cnt == NPTS) state <= S_SWAP;
        end
        S_SWAP: begin
          rd_bank  <= ~rd_bank;
          iter_cnt <= iter_cnt + ITER_W'(1);
          if (iter_cnt + ITER_W'(1) == iters) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state  <= S_SWEEP;
            wb_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (issue) begin
        sif.grid_addr <= cur_addr;
        issue_addr    <= next_addr(cur_addr);
      end
    end
  end

`ifdef SWEEP_PERF_CNT_EN
  logic [31:0] sweep_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles      <= '0;
      last_sweep_cycles <= '0;
      sweep_cyc         <= '0;
    end else begin
      if (start_acc) begin
        stall_cycles <= '0;
      end else if (state == S_SWEEP && !issue &&
                   stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (state == S_SWEEP || state == S_DRAIN) begin
        sweep_cyc <= sweep_cyc + 32'd1;
      end else begin
        sweep_cyc <= '0;
      end
      if (state == S_SWAP) last_sweep_cycles <= sweep_cyc;
    end
  end
`endif

endmodule

// File: tb/tb_jacobi_sweep_controller.sv
// Directed bench: 4x4 grid, 4-point credit limit, 24-cycle echo
// solver model with optional address swap and spurious writebacks.
module tb_jacobi_sweep_controller;

  localparam int GB   = 2;
  localparam int AW   = 2 * GB;
  localparam int IW   = 8;
  localparam int MAXI = 4;
  localparam int LAT  = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [IW-1:0] num_iters = '0;
  logic          rd_bank, busy, done;
  logic          err_order, err_underflow;
  logic [IW-1:0] iter_cnt;
`ifdef SWEEP_PERF_CNT_EN
  logic [31:0]   stall_cycles, last_sweep_cycles;
`endif

  jacobi_sweep_controller_if #(.GRID_BITS(GB)) sif ();

  jacobi_sweep_controller #(
    .GRID_BITS    (GB),
    .ITER_W       (IW),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_iters     (num_iters),
    .stall         (stall),
    .sif           (sif),
    .rd_bank       (rd_bank),
    .busy          (busy),
    .done          (done),
    .iter_cnt      (iter_cnt),
    .err_order     (err_order),
    .err_underflow (err_underflow)
`ifdef SWEEP_PERF_CNT_EN
    ,
    .stall_cycles      (stall_cycles),
    .last_sweep_cycles (last_sweep_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } wb_t;

  wb_t           q[$];
  int            cyc = 0;
  int            n_issue = 0, n_wb = 0, n_bad = 0, max_out = 0;
  int            n_done = 0, toggles = 0;
  int            cyc_last_wb = 0, cyc_done = 0;
  int            cyc_wb1 = 0, cyc_is5 = 0;
  logic [AW-1:0] exp_iss = '0;
  logic          prev_rd = 1'b0;
  int            clr_req = 0, clr_ack = 0;
  int            inj_req = 0, inj_ack = 0;
  bit            swap_mode = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Solver model and monitor, all on the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    wb_t w;
    cyc++;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      n_issue = 0; n_wb = 0; n_bad = 0; max_out = 0;
      n_done = 0; toggles = 0; exp_iss = '0;
      cyc_last_wb = 0; cyc_done = 0; cyc_wb1 = 0; cyc_is5 = 0;
    end
    if (rd_bank !== prev_rd) toggles++;
    prev_rd = rd_bank;
    if (done === 1'b1) begin
      n_done++;
      if (cyc_done == 0) cyc_done = cyc;
    end
    if (sif.solver_valid === 1'b1) begin
      n_issue++;
      if (n_issue == 5) cyc_is5 = cyc;
      if (sif.grid_addr !== exp_iss) n_bad++;
      exp_iss = exp_iss + 1'b1;
      a = sif.grid_addr;
      if (swap_mode && a == 4'd3) a = 4'd4;
      else if (swap_mode && a == 4'd4) a = 4'd3;
      q.push_back('{a: a, due: cyc + LAT});
    end
    sif.solver_valid_out = 1'b0;
    sif.solver_waddr = '0;
    if (inj_req != inj_ack) begin
      inj_ack = inj_req;
      sif.solver_valid_out = 1'b1;
      sif.solver_waddr = 4'd9;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      w = q.pop_front();
      sif.solver_valid_out = 1'b1;
      sif.solver_waddr = w.a;
      n_wb++;
      cyc_last_wb = cyc;
      if (n_wb == 1) cyc_wb1 = cyc;
    end
    if (n_issue - n_wb > max_out) max_out = n_issue - n_wb;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [IW-1:0] n);
    clr_req++;
    num_iters = n;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 64'(n_done != 0), 64'd1);
  endtask

  initial begin
    int vcnt;
    int k;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("reset_outputs",
        64'({sif.solver_valid, sif.grid_addr, rd_bank, busy, done,
             iter_cnt, err_order, err_underflow}), 64'd0);

    // single sweep, credit limit 4
    go(8'd1);
    wait_done("t1_done_seen", 600);
    step(5);
    chk("t1_issues", 64'(n_issue), 64'd16);
    chk("t1_raster", 64'(n_bad), 64'd0);
    chk("t1_max_outstanding", 64'(max_out), 64'd4);
    chk("t1_resume_gap", 64'(cyc_is5 - cyc_wb1), 64'd2);
    chk("t1_done_gap", 64'(cyc_done - cyc_last_wb), 64'd3);
    chk("t1_done_pulses", 64'(n_done), 64'd1);
    chk("t1_rd_bank", 64'(rd_bank), 64'd1);
    chk("t1_iter_cnt", 64'(iter_cnt), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // three sweeps
    go(8'd3);
    wait_done("t2_done_seen", 2000);
    step(5);
    chk("t2_issues", 64'(n_issue), 64'd48);
    chk("t2_raster", 64'(n_bad), 64'd0);
    chk("t2_done_pulses", 64'(n_done), 64'd1);
    chk("t2_iter_cnt", 64'(iter_cnt), 64'd3);
    chk("t2_bank_toggles", 64'(toggles), 64'd3);
    chk("t2_rd_bank", 64'(rd_bank), 64'd0);

    // stall for 10 cycles after two issues
    go(8'd1);
    k = 0;
    while (n_issue < 2 && k < 20) begin
      step(1);
      k++;
    end
    stall = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sif.solver_valid !== 1'b0) vcnt++;
    end
    stall = 1'b0;
    wait_done("t4_done_seen", 800);
    step(5);
    chk("t4_valid_in_stall", 64'(vcnt), 64'd0);
    chk("t4_issues", 64'(n_issue), 64'd16);
    chk("t4_raster", 64'(n_bad), 64'd0);

    // swapped writeback order, then spurious writeback when idle
    swap_mode = 1'b1;
    go(8'd1);
    wait_done("t5_done_seen", 800);
    step(5);
    swap_mode = 1'b0;
    chk("t5_err_order", 64'(err_order), 64'd1);
    step(10);
    chk("t5_err_order_sticky", 64'(err_order), 64'd1);
    chk("t5_done_pulses", 64'(n_done), 64'd1);
    chk("t5_no_underflow", 64'(err_underflow), 64'd0);
    inj_req++;
    step(2);
    chk("t5_err_underflow", 64'(err_underflow), 64'd1);

    // reset mid-sweep, then a zero-iteration solve
    go(8'd2);
    k = 0;
    while (n_issue < 5 && k < 100) begin
      step(1);
      k++;
    end
    rst = 1'b1;
    step(1);
    chk("t6_reset_outputs",
        64'({sif.solver_valid, sif.grid_addr, rd_bank, busy, done,
             iter_cnt, err_order, err_underflow}), 64'd0);
    rst = 1'b0;
    step(40);
    chk("t6_stale_underflow", 64'(err_underflow), 64'd1);
    chk("t6_idle_after_rst", 64'(busy), 64'd0);
    go(8'd0);
    chk("t6_zero_done", 64'(done), 64'd1);
    chk("t6_zero_err_clr", 64'(err_underflow), 64'd0);
    chk("t6_zero_busy", 64'(busy), 64'd0);
    step(1);
    chk("t6_done_drop", 64'(done), 64'd0);
    step(5);
    chk("t6_zero_issues", 64'(n_issue), 64'd0);
    chk("t6_zero_pulses", 64'(n_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
